// File: rtl/uart_arb_pkg.sv
// Shared types for the uart_tx arbiter: FSM state encoding and the buffered
// beat format (one byte plus its end-of-packet flag).
// Ports: none (package).
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {IDLE, OWN} arb_state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } arb_beat_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle between the requesters/uart_tx side and the arbiter.
// master: environment (requesters + uart_tx); slave: uart_tx_arb.
// Ports: req_data/last/vld/rdy per requester, uart_tx byte valid/ready, grant, busy.
interface uart_tx_arb_if #(
  parameter int N_REQ = 2
);
  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_last_i;
  logic [N_REQ-1:0]   req_vld_i;
  logic [N_REQ-1:0]   req_rdy_o;
  logic [7:0]         uart_tx_data_o;
  logic               uart_tx_data_vld_o;
  logic               uart_tx_data_rdy_i;
  logic [N_REQ-1:0]   grant_o;
  logic               busy_o;

  modport master (
    output req_data_i, req_last_i, req_vld_i, uart_tx_data_rdy_i,
    input  req_rdy_o, uart_tx_data_o, uart_tx_data_vld_o, grant_o, busy_o
  );

  modport slave (
    input  req_data_i, req_last_i, req_vld_i, uart_tx_data_rdy_i,
    output req_rdy_o, uart_tx_data_o, uart_tx_data_vld_o, grant_o, busy_o
  );
endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO of arb_beat_t; pop data is shown combinationally from the head.
// Latency: a push is visible at the head (empty=0) the cycle after it is taken.
// Backpressure: full blocks push even when a pop happens the same cycle.
// Ports: clk, rst, push/push_dat, pop/pop_dat, full, empty, count.
module byte_fifo
  import uart_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  arb_beat_t                  push_dat,
  input  logic                       pop,
  output arb_beat_t                  pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  arb_beat_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // full/empty come from the registered count only, so a pop cannot free a
  // slot for a push in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx byte channel between N_REQ FIFO-buffered
// requesters; a grant lasts one packet, capped by MAX_BURST bytes or IDLE_TMO empty cycles.
// Latency: push into idle arbiter at N -> grant at N+1 -> byte valid at N+2; 1 byte/cycle.
// Backpressure: output register holds until uart_tx_data_rdy_i; req_rdy_o = FIFO not full.
// Ports: clk_i, rst_i (sync, active high), bus (uart_tx_arb_if.slave).
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 16,
  parameter int IDLE_TMO   = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  uart_tx_arb_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(MAX_BURST+1);
  localparam int TW = $clog2(IDLE_TMO+1);
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);
  localparam logic [TW-1:0] TMO_LIM   = TW'(IDLE_TMO);

  arb_beat_t        fifo_in   [N_REQ];
  arb_beat_t        fifo_out  [N_REQ];
  logic [CW-1:0]    fifo_count[N_REQ];
  logic [N_REQ-1:0] fifo_full;
  logic [N_REQ-1:0] fifo_empty;
  logic [N_REQ-1:0] fifo_pop;

  arb_state_t    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [7:0]    out_dat;
  logic          out_vld;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          owner_has;
  logic          rel;

  function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= N_REQ) t = t - N_REQ;
    return IW'(t);
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    assign fifo_in[g] = '{last: bus.req_last_i[g], data: bus.req_data_i[8*g +: 8]};

    byte_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .push    (bus.req_vld_i[g]),
      .push_dat(fifo_in[g]),
      .pop     (fifo_pop[g]),
      .pop_dat (fifo_out[g]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g]),
      .count   (fifo_count[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
      tmo_cnt  <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_nxt     = rr_ptr;
    beat_nxt   = beat_cnt;
    tmo_nxt    = tmo_cnt;
    fifo_pop   = '0;
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    owner_has  = 1'b0;
    rel        = 1'b0;

    // Scan from the far end back toward rr_ptr so the closest non-empty
    // requester at/after rr_ptr is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (!fifo_empty[idx_add(rr_ptr, i)]) begin
        pick_found = 1'b1;
        pick_idx   = idx_add(rr_ptr, i);
      end
    end

    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = OWN;
          owner_nxt = pick_idx;
          beat_nxt  = '0;
          tmo_nxt   = '0;
        end
      end
      OWN: begin
        owner_has = (fifo_count[owner] != '0);
        if (owner_has && (!out_vld || bus.uart_tx_data_rdy_i)) begin
          fifo_pop[owner] = 1'b1;
          beat_nxt        = beat_cnt + 1'b1;
          tmo_nxt         = '0;
          rel             = fifo_out[owner].last || (beat_nxt == BURST_LIM);
        end else if (!owner_has) begin
          // Only an empty owner FIFO counts toward the timeout; a stalled
          // uart_tx with data still queued keeps the grant.
          tmo_nxt = (tmo_cnt == TMO_LIM) ? tmo_cnt : tmo_cnt + 1'b1;
          rel     = (tmo_nxt == TMO_LIM);
        end
        if (rel) begin
          state_nxt = IDLE;
          rr_nxt    = idx_add(owner, 1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register drains on its own; a pop only happens when it is free
  // or being emptied this cycle, so a new byte never overwrites a pending one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (|fifo_pop) begin
      out_vld <= 1'b1;
      out_dat <= fifo_out[owner].data;
    end else if (bus.uart_tx_data_rdy_i) begin
      out_vld <= 1'b0;
    end
  end

  always_comb begin
    bus.grant_o = '0;
    if (state == OWN) bus.grant_o[owner] = 1'b1;
  end

  assign bus.req_rdy_o          = ~fifo_full;
  assign bus.uart_tx_data_o     = out_dat;
  assign bus.uart_tx_data_vld_o = out_vld;
  assign bus.busy_o             = (state != IDLE) || out_vld;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed packets, expected bytes queued in issue order,
// a monitor compares every accepted output byte against the queue head.
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int N_REQ = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arb #(
    .N_REQ     (N_REQ),
    .FIFO_DEPTH(4),
    .MAX_BURST (16),
    .IDLE_TMO  (255)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] sb[$];
  arb_beat_t  fq0[$];
  arb_beat_t  fq1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic arb_beat_t mkb(input logic [7:0] d, input logic l);
    return '{last: l, data: d};
  endfunction

  // Drive requester r (others idle) for the coming edge.
  task automatic drv(input int r, input logic [7:0] d, input logic l, input logic v);
    bus.req_vld_i  = '0;
    bus.req_last_i = '0;
    bus.req_data_i = '0;
    bus.req_vld_i[r]         = v;
    bus.req_last_i[r]        = l;
    bus.req_data_i[8*r +: 8] = d;
  endtask

  // Present queued beats for both requesters; req0 held back until cycle d0.
  task automatic feed(input int bound, input int d0);
    int n;
    logic [N_REQ-1:0] acc;
    n = 0;
    while ((fq0.size() != 0 || fq1.size() != 0) && n < bound) begin
      @(negedge clk);
      bus.req_vld_i  = '0;
      bus.req_last_i = '0;
      bus.req_data_i = '0;
      if (fq0.size() != 0 && n >= d0) begin
        bus.req_vld_i[0]     = 1'b1;
        bus.req_last_i[0]    = fq0[0].last;
        bus.req_data_i[7:0]  = fq0[0].data;
      end
      if (fq1.size() != 0) begin
        bus.req_vld_i[1]     = 1'b1;
        bus.req_last_i[1]    = fq1[0].last;
        bus.req_data_i[15:8] = fq1[0].data;
      end
      acc = bus.req_vld_i & bus.req_rdy_o;
      @(posedge clk);
      if (acc[0]) void'(fq0.pop_front());
      if (acc[1]) void'(fq1.pop_front());
      n++;
    end
    @(negedge clk);
    bus.req_vld_i = '0;
    check("feed_done", fq0.size() + fq1.size(), 0);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    while (n < bound && (bus.busy_o || sb.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    check(name, {bus.busy_o, 31'(sb.size())}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_vld_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  // Monitor: samples just after the falling edge, i.e. what the DUT sees at the next rise.
  always begin : mon
    logic [7:0] e;
    @(negedge clk);
    #1;
    if (!rst && bus.uart_tx_data_vld_o && bus.uart_tx_data_rdy_i) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_extra: got byte 0x%0h, expected none", bus.uart_tx_data_o);
      end else begin
        e = sb.pop_front();
        check("sb_byte", bus.uart_tx_data_o, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_data_i = '0;
    bus.req_last_i = '0;
    bus.req_vld_i  = '0;
    bus.uart_tx_data_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_rdy", bus.req_rdy_o, 2'b11);
    check("rst_vld",     bus.uart_tx_data_vld_o, 0);
    check("rst_data",    bus.uart_tx_data_o, 0);
    check("rst_grant",   bus.grant_o, 0);
    check("rst_busy",    bus.busy_o, 0);
    rst = 1'b0;

    // 1: single packet, latency and grant timing
    sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
    drv(0, 8'h41, 1'b0, 1'b1);
    @(negedge clk);                       // edge N: 0x41 pushed
    check("t1_grant_n", bus.grant_o, 2'b00);
    drv(0, 8'h42, 1'b0, 1'b1);
    @(negedge clk);                       // N+1
    check("t1_grant_n1", bus.grant_o, 2'b01);
    check("t1_vld_n1", bus.uart_tx_data_vld_o, 0);
    drv(0, 8'h43, 1'b1, 1'b1);
    @(negedge clk);                       // N+2
    drv(0, 8'h00, 1'b0, 1'b0);
    check("t1_vld_n2", bus.uart_tx_data_vld_o, 1);
    check("t1_data_n2", bus.uart_tx_data_o, 8'h41);
    @(negedge clk);                       // N+3
    check("t1_grant_n3", bus.grant_o, 2'b01);
    @(negedge clk);                       // N+4: last popped, grant released
    check("t1_grant_n4", bus.grant_o, 2'b00);
    check("t1_data_n4", bus.uart_tx_data_o, 8'h43);
    wait_idle(50, "t1_drain");

    // 2: contention from rr_ptr=0, then rotation after a lone req0 packet
    do_reset();
    fq0.push_back(mkb(8'hA0, 1'b0)); fq0.push_back(mkb(8'hA1, 1'b1));
    fq1.push_back(mkb(8'hB0, 1'b0)); fq1.push_back(mkb(8'hB1, 1'b1));
    sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hB0); sb.push_back(8'hB1);
    feed(50, 0);
    wait_idle(50, "t2_drain_a");
    fq0.push_back(mkb(8'h50, 1'b1));
    sb.push_back(8'h50);
    feed(50, 0);
    wait_idle(50, "t2_drain_b");
    fq0.push_back(mkb(8'h51, 1'b1));
    fq1.push_back(mkb(8'h52, 1'b1));
    sb.push_back(8'h52); sb.push_back(8'h51);   // rr_ptr=1 now: req1 first
    feed(50, 0);
    wait_idle(50, "t2_drain_c");

    // 3: 20-byte stream from req1 without last; req0 packet arrives meanwhile
    do_reset();
    for (int i = 0; i < 20; i++) fq1.push_back(mkb(8'h80 + 8'(i), 1'b0));
    fq0.push_back(mkb(8'h30, 1'b0)); fq0.push_back(mkb(8'h31, 1'b1));
    for (int i = 0; i < 16; i++) sb.push_back(8'h80 + 8'(i));
    sb.push_back(8'h30); sb.push_back(8'h31);
    for (int i = 16; i < 20; i++) sb.push_back(8'h80 + 8'(i));
    feed(200, 3);
    wait_idle(400, "t3_drain");

    // 4: uart_tx stalled with a byte pending
    do_reset();
    bus.uart_tx_data_rdy_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fq0.push_back(mkb(8'h60 + 8'(i), i == 5));
      sb.push_back(8'h60 + 8'(i));
    end
    fork
      feed(200, 0);
    join_none
    repeat (8) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      check("t4_vld_hold", bus.uart_tx_data_vld_o, 1);
      check("t4_data_hold", bus.uart_tx_data_o, 8'h60);
      @(negedge clk);
    end
    check("t4_req_rdy_full", bus.req_rdy_o[0], 0);
    check("t4_sixth_waits", fq0.size(), 1);
    bus.uart_tx_data_rdy_i = 1'b1;
    wait fork;
    wait_idle(50, "t4_drain");

    // 5: one byte without last, then the owner goes quiet
    do_reset();
    sb.push_back(8'h22);
    drv(0, 8'h22, 1'b0, 1'b1);
    @(negedge clk);                       // edge N
    drv(0, 8'h00, 1'b0, 1'b0);
    repeat (256) @(negedge clk);          // edge N+256: 254 empty cycles so far
    check("t5_grant_hold", bus.grant_o, 2'b01);
    @(negedge clk);                       // edge N+257: 255th empty cycle releases
    check("t5_grant_rel", bus.grant_o, 2'b00);
    check("t5_busy_rel", bus.busy_o, 0);
    wait_idle(20, "t5_drain");

    // 6: reset in the middle of a packet
    do_reset();
    bus.uart_tx_data_rdy_i = 1'b0;
    sb.push_back(8'h11);
    drv(0, 8'h11, 1'b0, 1'b1); @(negedge clk);
    drv(0, 8'h12, 1'b0, 1'b1); @(negedge clk);
    drv(0, 8'h13, 1'b0, 1'b1); @(negedge clk);
    drv(0, 8'h00, 1'b0, 1'b0);
    check("t6_vld_before", bus.uart_tx_data_vld_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_vld_rst", bus.uart_tx_data_vld_o, 0);
    check("t6_grant_rst", bus.grant_o, 0);
    check("t6_req_rdy_rst", bus.req_rdy_o, 2'b11);
    check("t6_busy_rst", bus.busy_o, 0);
    rst = 1'b0;
    sb.delete();
    bus.uart_tx_data_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_resume", {bus.busy_o, bus.uart_tx_data_vld_o}, 0);
    sb.push_back(8'h77);
    drv(0, 8'h77, 1'b1, 1'b1);
    @(negedge clk);
    drv(0, 8'h00, 1'b0, 1'b0);
    wait_idle(50, "t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
